// File: rtl/sma_chan_sched.sv
// Round-robin scheduler sharing one TAPS-deep moving-average datapath among CHANNELS streams.
// Keeps per-channel tap history and accumulator, with a sequenced one-channel-per-cycle flush.
module sma_chan_sched #(
   parameter int unsigned CHANNELS  = 4,
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned TAPS_LOG2 = 2,
   localparam int unsigned CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [CHANNELS-1:0]         in_valid,
   input  logic [CHANNELS*DATA_W-1:0]  in_data,
   output logic [CHANNELS-1:0]         in_ready,
   input  logic                        flush,
   output logic                        busy,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic signed [DATA_W-1:0]    out_data,
   output logic [CW-1:0]               out_chan
);

   localparam int unsigned TAPS = 2 ** TAPS_LOG2;
   localparam int unsigned AW   = DATA_W + TAPS_LOG2;

   typedef enum logic {StRun, StFlush} state_e;

   state_e                   state_q;
   logic signed [DATA_W-1:0] hist_q [CHANNELS][TAPS];
   logic signed [AW-1:0]     acc_q  [CHANNELS];
   logic [CW-1:0]            ptr_q;
   logic [CW-1:0]            flush_idx_q;
   logic                     busy_q;
   logic                     out_valid_q;
   logic signed [DATA_W-1:0] out_data_q;
   logic [CW-1:0]            out_chan_q;

   logic signed [DATA_W-1:0] samples [CHANNELS];
   logic                     grant_valid;
   logic [CW-1:0]            grant_idx;
   logic [CW-1:0]            cand;
   logic                     stage_free;
   logic                     xfer;
   logic signed [DATA_W-1:0] x;
   logic signed [AW-1:0]     x_ext;
   logic signed [AW-1:0]     old_ext;
   logic signed [AW-1:0]     acc_d;
   logic signed [AW-1:0]     avg;
   logic signed [DATA_W-1:0] out_data_d;

   for (genvar c = 0; c < int'(CHANNELS); c++) begin : g_unpack
      assign samples[c] = in_data[c*DATA_W +: DATA_W];
   end

   // Search starts one past the last-served channel, wrapping around.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int i = 1; i <= int'(CHANNELS); i++) begin
         cand = CW'((int'(ptr_q) + i) % int'(CHANNELS));
         if (!grant_valid && in_valid[cand]) begin
            grant_valid = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   assign stage_free = !out_valid_q || out_ready;
   // A flush request takes priority over any grant in the same cycle.
   assign xfer       = (state_q == StRun) && stage_free && !flush && grant_valid;

   always_comb begin
      in_ready = '0;
      for (int c = 0; c < int'(CHANNELS); c++) begin
         in_ready[c] = xfer && (grant_idx == CW'(c));
      end
   end

   assign x          = samples[grant_idx];
   assign x_ext      = {{TAPS_LOG2{x[DATA_W-1]}}, x};
   assign old_ext    = {{TAPS_LOG2{hist_q[grant_idx][TAPS-1][DATA_W-1]}},
                        hist_q[grant_idx][TAPS-1]};
   assign acc_d      = acc_q[grant_idx] - old_ext + x_ext;
   assign avg        = acc_d >>> TAPS_LOG2;
   assign out_data_d = {avg[AW-1], avg[DATA_W-2:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StRun;
         ptr_q       <= CW'(CHANNELS - 1);
         flush_idx_q <= '0;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_chan_q  <= '0;
         for (int c = 0; c < int'(CHANNELS); c++) begin
            acc_q[c] <= '0;
            for (int t = 0; t < int'(TAPS); t++) begin
               hist_q[c][t] <= '0;
            end
         end
      end else begin
         if (xfer) begin
            ptr_q                <= grant_idx;
            acc_q[grant_idx]     <= acc_d;
            hist_q[grant_idx][0] <= x;
            for (int t = 1; t < int'(TAPS); t++) begin
               hist_q[grant_idx][t] <= hist_q[grant_idx][t-1];
            end
            out_valid_q <= 1'b1;
            out_data_q  <= out_data_d;
            out_chan_q  <= grant_idx;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end

         case (state_q)
            StRun: begin
               if (flush) begin
                  state_q     <= StFlush;
                  flush_idx_q <= '0;
                  busy_q      <= 1'b1;
               end
            end
            StFlush: begin
               acc_q[flush_idx_q] <= '0;
               for (int t = 0; t < int'(TAPS); t++) begin
                  hist_q[flush_idx_q][t] <= '0;
               end
               if (flush_idx_q == CW'(CHANNELS - 1)) begin
                  state_q <= StRun;
                  busy_q  <= 1'b0;
               end else begin
                  flush_idx_q <= flush_idx_q + 1'b1;
               end
            end
            default: state_q <= StRun;
         endcase
      end
   end

   assign busy      = busy_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_sma_chan_sched.sv
// Directed self-checking bench for sma_chan_sched with 4 channels of 16-bit samples.
module tb_sma_chan_sched;

   localparam int CH = 4;
   localparam int DW = 16;

   logic                    clk;
   logic                    rst;
   logic [CH-1:0]           in_valid;
   logic [CH*DW-1:0]        in_data;
   logic [CH-1:0]           in_ready;
   logic                    flush;
   logic                    busy;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [DW-1:0]    out_data;
   logic [1:0]              out_chan;

   int n_checks = 0;
   int n_fail   = 0;

   sma_chan_sched #(
      .CHANNELS  (CH),
      .DATA_W    (DW),
      .TAPS_LOG2 (2)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .flush     (flush),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_chan  (out_chan)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input int c, input int v);
      in_data[c*DW +: DW] = DW'(v);
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      in_valid  = '0;
      flush     = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   int exp3 [8] = '{-8192, -16384, -24576, -32768, -16385, -1, 16383, 32767};
   int exp1 [5] = '{25, 50, 75, 100, 100};

   initial begin
      in_data = '0;
      do_reset();

      // Reset state and single requester
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_chan", out_chan, 0);
      in_valid = 4'b0001;
      set_data(0, 100);
      for (int k = 0; k < 5; k++) begin
         #1;
         check("t1_in_ready", in_ready, 1);
         tick();
         check("t1_out_valid", out_valid, 1);
         check("t1_out_data", out_data, exp1[k]);
         check("t1_out_chan", out_chan, 0);
      end
      in_valid = '0;
      tick();
      check("t1_drain", out_valid, 0);

      // All channels requesting: strict round-robin, full throughput
      do_reset();
      in_valid = 4'b1111;
      for (int c = 0; c < CH; c++) set_data(c, (c + 1) * 40);
      for (int k = 0; k < 20; k++) begin
         #1;
         check("t2_grant", in_ready, 1 << (k % 4));
         tick();
         check("t2_out_valid", out_valid, 1);
         check("t2_out_chan", out_chan, k % 4);
         check("t2_out_data", out_data, ((k / 4 < 4) ? (k / 4 + 1) : 4) * ((k % 4) + 1) * 10);
      end
      in_valid = '0;
      tick();

      // Full-scale negative then positive samples on channel 1
      do_reset();
      in_valid = 4'b0010;
      for (int k = 0; k < 8; k++) begin
         set_data(1, (k < 4) ? -32768 : 32767);
         #1;
         check("t3_in_ready", in_ready, 2);
         tick();
         check("t3_out_data", out_data, exp3[k]);
         check("t3_out_chan", out_chan, 1);
      end
      in_valid = '0;
      tick();

      // Backpressure holds the output and blocks grants
      do_reset();
      out_ready = 1'b0;
      in_valid  = 4'b0101;
      set_data(0, 40);
      set_data(2, 80);
      #1;
      check("t4_first_grant", in_ready, 1);
      tick();
      for (int k = 0; k < 3; k++) begin
         check("t4_stall_ready", in_ready, 0);
         check("t4_stall_valid", out_valid, 1);
         check("t4_stall_data", out_data, 10);
         check("t4_stall_chan", out_chan, 0);
         tick();
      end
      out_ready = 1'b1;
      #1;
      check("t4_resume_grant", in_ready, 4);
      tick();
      check("t4_resume_data", out_data, 20);
      check("t4_resume_chan", out_chan, 2);
      in_valid = '0;
      tick();
      check("t4_drain", out_valid, 0);

      // Flush with a pending result
      do_reset();
      in_valid = 4'b0001;
      set_data(0, 400);
      set_data(3, 400);
      for (int k = 0; k < 4; k++) tick();
      in_valid = 4'b1000;
      for (int k = 0; k < 4; k++) tick();
      out_ready = 1'b0;
      flush     = 1'b1;
      in_valid  = 4'b1001;
      #1;
      check("t5_flush_cycle_ready", in_ready, 0);
      tick();
      flush = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("t5_busy", busy, 1);
         check("t5_ready_in_flush", in_ready, 0);
         if (i == 0) begin
            check("t5_pending_valid", out_valid, 1);
            check("t5_pending_data", out_data, 400);
            check("t5_pending_chan", out_chan, 3);
         end
         if (i == 3) check("t5_delivered", out_valid, 0);
         out_ready = (i == 1);
         tick();
      end
      check("t5_busy_done", busy, 0);
      out_ready = 1'b1;
      in_valid  = 4'b0001;
      #1;
      check("t5_post_grant0", in_ready, 1);
      tick();
      check("t5_post_data0", out_data, 100);
      check("t5_post_chan0", out_chan, 0);
      in_valid = 4'b1000;
      #1;
      check("t5_post_grant3", in_ready, 8);
      tick();
      check("t5_post_data3", out_data, 100);
      check("t5_post_chan3", out_chan, 3);
      in_valid = '0;
      tick();

      // Reset mid-stream
      do_reset();
      in_valid = 4'b0010;
      set_data(1, 200);
      tick();
      tick();
      check("t6_pre_valid", out_valid, 1);
      check("t6_pre_data", out_data, 100);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6_rst_valid", out_valid, 0);
      check("t6_rst_data", out_data, 0);
      check("t6_rst_busy", busy, 0);
      in_valid = 4'b0101;
      set_data(0, 80);
      set_data(2, 120);
      #1;
      check("t6_grant0", in_ready, 1);
      tick();
      check("t6_data0", out_data, 20);
      check("t6_chan0", out_chan, 0);
      #1;
      check("t6_grant2", in_ready, 4);
      tick();
      check("t6_data2", out_data, 30);
      check("t6_chan2", out_chan, 2);
      in_valid = 4'b0010;
      #1;
      check("t6_grant1", in_ready, 2);
      tick();
      check("t6_data1", out_data, 50);
      in_valid = '0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
